// File: rtl/riscv_mmio_timer.sv
// Machine-timer and tohost mailbox peripheral on the core's data-memory bus.
// Provides a prescaled 64-bit mtime, a 64-bit mtimecmp, a registered timer interrupt and a sticky mailbox.
module riscv_mmio_timer #(
   parameter int XLEN     = 32,
   parameter int ADDR_BIT = 5,
   parameter int PRESCALE = 1
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_sel,
   input  logic [ADDR_BIT-1:0] i_addr,
   input  logic                i_wr_en,
   input  logic [3:0]          i_byte_sel,
   input  logic [XLEN-1:0]     i_wr_data,
   output logic [XLEN-1:0]     o_rd_data,
   output logic                o_timer_irq,
   output logic                o_tohost_valid,
   output logic [XLEN-1:0]     o_tohost_data
);

   localparam int WORD_BIT = ADDR_BIT - 2;
   localparam logic [WORD_BIT-1:0] REG_MTIME_LO = WORD_BIT'(0);
   localparam logic [WORD_BIT-1:0] REG_MTIME_HI = WORD_BIT'(1);
   localparam logic [WORD_BIT-1:0] REG_CMP_LO   = WORD_BIT'(2);
   localparam logic [WORD_BIT-1:0] REG_CMP_HI   = WORD_BIT'(3);
   localparam logic [WORD_BIT-1:0] REG_CTRL     = WORD_BIT'(4);
   localparam logic [WORD_BIT-1:0] REG_TOHOST   = WORD_BIT'(5);
   localparam logic [15:0]         PRE_LAST     = 16'(PRESCALE - 1);

   function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] cur,
                                                   input logic [XLEN-1:0] wdata,
                                                   input logic [3:0]      lanes);
      logic [XLEN-1:0] res;
      res = cur;
      for (int n = 0; n < 4; n++) begin
         if (lanes[n]) res[8*n +: 8] = wdata[8*n +: 8];
      end
      return res;
   endfunction

   logic [63:0]         mtime_r, mtime_nxt_s;
   logic [63:0]         mtimecmp_r;
   logic [15:0]         pre_cnt_r, pre_cnt_nxt_s;
   logic                en_r;
   logic                irq_r;
   logic                tohost_valid_r;
   logic [XLEN-1:0]     tohost_data_r;
   logic [XLEN-1:0]     rd_data_s;
   logic [WORD_BIT-1:0] word_s;
   logic                wr_s, tick_s;
   logic                wr_mtime_lo_s, wr_mtime_hi_s, wr_cmp_lo_s, wr_cmp_hi_s;
   logic                wr_ctrl_s, wr_tohost_s;
   logic                unused_addr_s;

   // An all-zero lane mask is treated as no access at all, so it never steals a tick.
   assign word_s        = i_addr[ADDR_BIT-1:2];
   assign unused_addr_s = ^i_addr[1:0];
   assign wr_s          = i_sel & i_wr_en & (|i_byte_sel);
   assign wr_mtime_lo_s = wr_s & (word_s == REG_MTIME_LO);
   assign wr_mtime_hi_s = wr_s & (word_s == REG_MTIME_HI);
   assign wr_cmp_lo_s   = wr_s & (word_s == REG_CMP_LO);
   assign wr_cmp_hi_s   = wr_s & (word_s == REG_CMP_HI);
   assign wr_ctrl_s     = wr_s & (word_s == REG_CTRL);
   assign wr_tohost_s   = wr_s & (word_s == REG_TOHOST);
   assign tick_s        = en_r & (pre_cnt_r == PRE_LAST);

   // Prescaler and mtime next state; a software write to either half drops that cycle's increment.
   always_comb begin
      pre_cnt_nxt_s = pre_cnt_r;
      mtime_nxt_s   = mtime_r;
      if (!en_r)                      pre_cnt_nxt_s = pre_cnt_r;
      else if (pre_cnt_r == PRE_LAST) pre_cnt_nxt_s = 16'd0;
      else                            pre_cnt_nxt_s = pre_cnt_r + 16'd1;
      if (wr_mtime_lo_s)      mtime_nxt_s[31:0]  = merge_bytes(mtime_r[31:0], i_wr_data, i_byte_sel);
      else if (wr_mtime_hi_s) mtime_nxt_s[63:32] = merge_bytes(mtime_r[63:32], i_wr_data, i_byte_sel);
      else if (tick_s)        mtime_nxt_s        = mtime_r + 64'd1;
      else                    mtime_nxt_s        = mtime_r;
   end

   // State registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         mtime_r        <= 64'd0;
         mtimecmp_r     <= 64'hFFFF_FFFF_FFFF_FFFF;
         pre_cnt_r      <= 16'd0;
         en_r           <= 1'b0;
         irq_r          <= 1'b0;
         tohost_valid_r <= 1'b0;
         tohost_data_r  <= '0;
      end else begin
         mtime_r   <= mtime_nxt_s;
         pre_cnt_r <= pre_cnt_nxt_s;
         irq_r     <= en_r & (mtime_r >= mtimecmp_r);
         if (wr_cmp_lo_s) mtimecmp_r[31:0] <= merge_bytes(mtimecmp_r[31:0], i_wr_data, i_byte_sel);
         else if (wr_cmp_hi_s) mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], i_wr_data, i_byte_sel);
         else mtimecmp_r <= mtimecmp_r;
         if (wr_ctrl_s && i_byte_sel[0]) en_r <= i_wr_data[0];
         else en_r <= en_r;
         if (wr_tohost_s) begin
            tohost_valid_r <= 1'b1;
            tohost_data_r  <= merge_bytes(tohost_data_r, i_wr_data, i_byte_sel);
         end else begin
            tohost_valid_r <= tohost_valid_r;
            tohost_data_r  <= tohost_data_r;
         end
      end
   end

   // Zero-latency read mux so a single-cycle core can load in the same cycle.
   always_comb begin
      rd_data_s = '0;
      if (i_sel) begin
         case (word_s)
            REG_MTIME_LO: rd_data_s = mtime_r[31:0];
            REG_MTIME_HI: rd_data_s = mtime_r[63:32];
            REG_CMP_LO:   rd_data_s = mtimecmp_r[31:0];
            REG_CMP_HI:   rd_data_s = mtimecmp_r[63:32];
            REG_CTRL:     rd_data_s = {{(XLEN-2){1'b0}}, irq_r, en_r};
            REG_TOHOST:   rd_data_s = tohost_data_r;
            default:      rd_data_s = '0;
         endcase
      end else begin
         rd_data_s = '0;
      end
   end

   assign o_rd_data      = rd_data_s;
   assign o_timer_irq    = irq_r;
   assign o_tohost_valid = tohost_valid_r;
   assign o_tohost_data  = tohost_data_r;

endmodule

// File: tb/tb_riscv_mmio_timer.sv
// Directed scoreboard bench for riscv_mmio_timer: one instance with PRESCALE=4, one with PRESCALE=1,
// sharing every bus signal except the select.
module tb_riscv_mmio_timer;

   logic        clk;
   logic        rstn;
   logic        sel4, sel1;
   logic [4:0]  addr;
   logic        wr_en;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rd4, rd1, td4, td1;
   logic        irq4, irq1, tv4, tv1;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   riscv_mmio_timer #(.XLEN(32), .ADDR_BIT(5), .PRESCALE(4)) u_p4 (
      .i_clk(clk), .i_rstn(rstn), .i_sel(sel4), .i_addr(addr), .i_wr_en(wr_en),
      .i_byte_sel(be), .i_wr_data(wdata), .o_rd_data(rd4), .o_timer_irq(irq4),
      .o_tohost_valid(tv4), .o_tohost_data(td4));

   riscv_mmio_timer #(.XLEN(32), .ADDR_BIT(5), .PRESCALE(1)) u_p1 (
      .i_clk(clk), .i_rstn(rstn), .i_sel(sel1), .i_addr(addr), .i_wr_en(wr_en),
      .i_byte_sel(be), .i_wr_data(wdata), .o_rd_data(rd1), .o_timer_irq(irq1),
      .o_tohost_valid(tv1), .o_tohost_data(td1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input bit p1, input logic [4:0] a, input logic [31:0] d, input logic [3:0] lanes);
      addr = a; wdata = d; be = lanes; wr_en = 1'b1;
      if (p1) sel1 = 1'b1; else sel4 = 1'b1;
      @(negedge clk);
      sel1 = 1'b0; sel4 = 1'b0; wr_en = 1'b0; be = 4'd0; wdata = 32'd0;
   endtask

   task automatic rd(input bit p1, input logic [4:0] a, input logic [31:0] e, input string tag);
      push(e);
      addr = a; wr_en = 1'b0;
      if (p1) sel1 = 1'b1; else sel4 = 1'b1;
      #1;
      chk(tag, p1 ? rd1 : rd4);
      sel1 = 1'b0; sel4 = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; sel4 = 1'b0; sel1 = 1'b0; addr = 5'd0; wr_en = 1'b0; be = 4'd0; wdata = 32'd0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // 1: reset state after idling
      idle(10);
      rd(1'b0, 5'h00, 32'd0, "rst_mtime_lo");
      rd(1'b0, 5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
      rd(1'b0, 5'h10, 32'd0, "rst_ctrl");
      push(32'd0); chk("rst_irq", {31'd0, irq4});
      push(32'd0); chk("rst_tohost_valid", {31'd0, tv4});
      push(32'd0); #1 chk("rd_unselected", rd4);

      // 2: prescaler 4, 40 cycles -> 10 ticks, then freeze
      wr(1'b0, 5'h10, 32'd1, 4'hF);
      idle(40);
      rd(1'b0, 5'h00, 32'd10, "p4_mtime_lo");
      rd(1'b0, 5'h04, 32'd0, "p4_mtime_hi");
      wr(1'b0, 5'h10, 32'd0, 4'hF);
      rd(1'b0, 5'h00, 32'd10, "p4_disabled");
      idle(20);
      rd(1'b0, 5'h00, 32'd10, "p4_frozen");

      // 3: carry and wrap with prescaler 1
      wr(1'b1, 5'h00, 32'hFFFF_FFFE, 4'hF);
      wr(1'b1, 5'h04, 32'd0, 4'hF);
      wr(1'b1, 5'h10, 32'd1, 4'hF);
      idle(2);
      rd(1'b1, 5'h00, 32'd0, "carry_lo");
      rd(1'b1, 5'h04, 32'd1, "carry_hi");
      wr(1'b1, 5'h00, 32'hFFFF_FFFF, 4'hF);
      wr(1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF);
      rd(1'b1, 5'h00, 32'hFFFF_FFFF, "collide_lo_held");
      rd(1'b1, 5'h04, 32'hFFFF_FFFF, "collide_hi_loaded");
      idle(1);
      rd(1'b1, 5'h00, 32'd0, "wrap_lo");
      rd(1'b1, 5'h04, 32'd0, "wrap_hi");

      // 4: interrupt timing
      wr(1'b1, 5'h10, 32'd0, 4'hF);
      wr(1'b1, 5'h00, 32'd0, 4'hF);
      wr(1'b1, 5'h0C, 32'd0, 4'hF);
      wr(1'b1, 5'h08, 32'd20, 4'hF);
      wr(1'b1, 5'h10, 32'd1, 4'hF);
      idle(20);
      rd(1'b1, 5'h00, 32'd20, "irq_mtime_at_cmp");
      push(32'd0); chk("irq_not_yet", {31'd0, irq1});
      idle(1);
      push(32'd1); chk("irq_rise", {31'd0, irq1});
      rd(1'b1, 5'h10, 32'd3, "ctrl_pending");
      wr(1'b1, 5'h08, 32'd1000, 4'hF);
      push(32'd1); chk("irq_hold_one_cycle", {31'd0, irq1});
      idle(1);
      push(32'd0); chk("irq_drop", {31'd0, irq1});

      // 5: byte lanes and unmapped space
      wr(1'b1, 5'h08, 32'h1122_3344, 4'hF);
      wr(1'b1, 5'h08, 32'hAABB_CCDD, 4'b0101);
      rd(1'b1, 5'h08, 32'h11BB_33DD, "byte_lane_merge");
      wr(1'b1, 5'h08, 32'hAABB_CCDD, 4'b0000);
      rd(1'b1, 5'h08, 32'h11BB_33DD, "byte_lane_none");
      wr(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF);
      rd(1'b1, 5'h18, 32'd0, "unmapped_18");
      rd(1'b1, 5'h1C, 32'd0, "unmapped_1c");

      // 6: mailbox, then asynchronous reset while counting with irq high
      wr(1'b1, 5'h14, 32'd1, 4'hF);
      push(32'd1); chk("tohost_valid_set", {31'd0, tv1});
      push(32'd1); chk("tohost_data_1", td1);
      rd(1'b1, 5'h14, 32'd1, "tohost_read");
      wr(1'b1, 5'h14, 32'h2A, 4'hF);
      push(32'd1); chk("tohost_valid_sticky", {31'd0, tv1});
      push(32'h2A); chk("tohost_data_2a", td1);
      wr(1'b1, 5'h08, 32'd5, 4'hF);
      idle(1);
      push(32'd1); chk("irq_before_reset", {31'd0, irq1});
      #2 rstn = 1'b0;
      #1;
      push(32'd0); chk("arst_irq", {31'd0, irq1});
      push(32'd0); chk("arst_tohost_valid", {31'd0, tv1});
      push(32'd0); chk("arst_tohost_data", td1);
      rd(1'b1, 5'h00, 32'd0, "arst_mtime_p1");
      rd(1'b0, 5'h00, 32'd0, "arst_mtime_p4");
      rd(1'b1, 5'h0C, 32'hFFFF_FFFF, "arst_cmp_hi");
      rd(1'b1, 5'h10, 32'd0, "arst_ctrl");
      @(negedge clk);
      rstn = 1'b1;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
